// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MDU_WAIT   = 2'd2
   } state_t;

   localparam int unsigned ZERO_REG       = 0;
   localparam int unsigned DEF_LOAD_LAT   = 1;
   localparam int unsigned DEF_MDU_CYCLES = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a load in ID/EX whose destination feeds the IF/ID instruction.
module hazard_detect #(
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                  mem_read,
   input  logic [REG_ADDR_W-1:0] load_rt,
   input  logic [REG_ADDR_W-1:0] src_rs,
   input  logic [REG_ADDR_W-1:0] src_rt,
   input  logic                  uses_rt,
   output logic                  lu_hit
);
   import hazard_pkg::*;

   logic dest_live;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign dest_live = (load_rt != REG_ADDR_W'(ZERO_REG));

   assign lu_hit = mem_read && dest_live &&
                   ((load_rt == src_rs) || (uses_rt && (load_rt == src_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use bubbles, MDU hold in EX and taken-branch squash.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned LOAD_LAT   = DEF_LOAD_LAT,
   parameter int unsigned MDU_CYCLES = DEF_MDU_CYCLES,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  idex_mem_read,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic                  idex_mdu,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   input  logic                  ifid_uses_rt,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  stall_active,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu_hit;

   hazard_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_detect (
      .mem_read (idex_mem_read),
      .load_rt  (idex_rt),
      .src_rs   (ifid_rs),
      .src_rt   (ifid_rt),
      .uses_rt  (ifid_uses_rt),
      .lu_hit   (lu_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_write = 1'b1;
      idex_flush = 1'b0;

      case (state)
         RUN: begin
            if (branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (idex_mdu) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_write = 1'b0;
               // This RUN cycle is the first held cycle and MDU_WAIT lasts cnt+1
               // cycles, so MDU_CYCLES-3 gives MDU_CYCLES-1 held cycles in total.
               if (MDU_CYCLES > 2) begin
                  cnt_nxt   = 4'(MDU_CYCLES - 3);
                  state_nxt = MDU_WAIT;
               end
            end else if (lu_hit) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               if (LOAD_LAT > 1) begin
                  cnt_nxt   = 4'(LOAD_LAT - 2);
                  state_nxt = LOAD_STALL;
               end
            end
         end
         LOAD_STALL: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - 4'd1;
         end
         MDU_WAIT: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = RUN;
      endcase

      if (rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   assign stall_active = !rst && !pc_write;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_active && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if ((state == RUN) && branch_taken && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule
